lcd_hd44780_timing_engine: RTL

//  Downstream stage of the lcd_v3_0 AXI4-Lite register file.

---
 rtl/lcd_hd44780_timing_engine_pkg.sv | 29 ++
 rtl/lcd_hd44780_timing_engine_if.sv | 10 +
 rtl/lcd_hd44780_timing_engine_init_rom.sv | 27 ++
 rtl/lcd_hd44780_timing_engine.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_hd44780_timing_engine_pkg.sv
// Shared types and constants for the HD44780 timing engine: FSM states,
// instruction bytes and the clear/home decode used to pick the long wait.
package lcd_hd44780_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
    localparam logic [7:0] FUNC_8BIT_2LINE = 8'h38;
    localparam logic [7:0] DISP_ON         = 8'h0C;
    localparam logic [7:0] ENTRY_INC       = 8'h06;

    // Clear (0x01) and home (0x02/0x03) need the long execution time.
    function automatic logic is_clear_class(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0) && (data != 8'd0);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_hd44780_timing_engine_if.sv
// Command byte handshake between the register file (master) and the engine (slave).
interface lcd_hd44780_timing_engine_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, output cmd_rs, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_rs, input cmd_data, output cmd_ready);
endinterface

// File: rtl/lcd_hd44780_timing_engine_init_rom.sv
// Power-on initialization byte table (8-bit, 2-line, display on, clear, entry increment).
// Only instantiated when LCD_INIT_SEQ_EN is defined.
module lcd_init_rom
    import lcd_hd44780_pkg::*;
(
    input  logic [2:0] idx,
    output logic [7:0] data,
    output logic       last
);

    always_comb begin
        data = ENTRY_INC;
        last = 1'b0;
        unique case (idx)
            3'd0:    data = FUNC_8BIT_2LINE;
            3'd1:    data = FUNC_8BIT_2LINE;
            3'd2:    data = FUNC_8BIT_2LINE;
            3'd3:    data = DISP_ON;
            3'd4:    data = LCD_CMD_CLEAR;
            default: begin
                data = ENTRY_INC;
                last = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lcd_hd44780_timing_engine.sv
// HD44780 8-bit write engine: setup, E pulse, hold and execution wait per byte.
// Define LCD_INIT_SEQ_EN to add the power-up delay and built-in init sequence.
module lcd_hd44780_timing_engine
    import lcd_hd44780_pkg::*;
#(
    parameter int unsigned T_AS_CYC    = 4,
    parameter int unsigned T_PW_CYC    = 25,
    parameter int unsigned T_H_CYC     = 2,
    parameter int unsigned T_EXEC_CYC  = 4000,
    parameter int unsigned T_CLR_CYC   = 164000,
    parameter int unsigned T_PWRUP_CYC = 1500000
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    lcd_hd44780_timing_engine_if.slave   cmd,
    output logic                         busy,
    output logic                         init_done,
    output logic                         lcd_e,
    output logic                         lcd_rs,
    output logic                         lcd_rw,
    output logic [7:0]                   lcd_db
);

    localparam int unsigned MAX_T = max_u(max_u(max_u(T_AS_CYC, T_PW_CYC), max_u(T_H_CYC, T_EXEC_CYC)),
                                          max_u(T_CLR_CYC, T_PWRUP_CYC));
    localparam int CNT_W = $clog2(MAX_T + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LD_AS   = cnt_t'(T_AS_CYC - 1);
    localparam cnt_t LD_PW   = cnt_t'(T_PW_CYC - 1);
    localparam cnt_t LD_H    = cnt_t'(T_H_CYC - 1);
    localparam cnt_t LD_EXEC = cnt_t'(T_EXEC_CYC - 1);
    localparam cnt_t LD_CLR  = cnt_t'(T_CLR_CYC - 1);

    lcd_state_e state, state_n;
    cnt_t       cnt, cnt_n;
    logic       clr_q;
    logic       load_cmd;
    logic       init_done_n;
    logic       accept;

    assign cmd.cmd_ready = (state == IDLE) && init_done;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign lcd_rw        = 1'b0;

`ifdef LCD_INIT_SEQ_EN
    localparam cnt_t LD_PWRUP = cnt_t'(T_PWRUP_CYC - 1);

    logic [2:0] idx;
    logic [7:0] rom_data;
    logic       rom_last;
    logic       last_q;
    logic       load_rom;
    logic       init_fin;

    lcd_init_rom u_init_rom (
        .idx  (idx),
        .data (rom_data),
        .last (rom_last)
    );

    assign init_done_n = init_done || init_fin;
`else
    assign init_done_n = 1'b1;
`endif

    // One down-counter is reloaded on every state change with the next phase length.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        load_cmd = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        load_rom = 1'b0;
        init_fin = 1'b0;
`endif
        unique case (state)
            PWRUP: begin
`ifdef LCD_INIT_SEQ_EN
                if (cnt == '0) begin
                    state_n  = SETUP;
                    cnt_n    = LD_AS;
                    load_rom = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
`else
                state_n = IDLE;
`endif
            end
            IDLE: begin
                if (accept) begin
                    state_n  = SETUP;
                    cnt_n    = LD_AS;
                    load_cmd = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_n = PULSE;
                    cnt_n   = LD_PW;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_n = HOLD;
                    cnt_n   = LD_H;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n = WAIT;
                    cnt_n   = clr_q ? LD_CLR : LD_EXEC;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
                    if (!init_done && !last_q) begin
                        state_n  = SETUP;
                        cnt_n    = LD_AS;
                        load_rom = 1'b1;
                    end else begin
                        state_n  = IDLE;
                        init_fin = !init_done;
                    end
`else
                    state_n = IDLE;
`endif
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they are glitch-free and all clear on reset.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
`ifdef LCD_INIT_SEQ_EN
            state  <= PWRUP;
            cnt    <= LD_PWRUP;
            idx    <= 3'd0;
            last_q <= 1'b0;
`else
            state  <= IDLE;
            cnt    <= '0;
`endif
            clr_q     <= 1'b0;
            init_done <= 1'b0;
            busy      <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_db    <= 8'h00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            init_done <= init_done_n;
            busy      <= (state_n != IDLE) || !init_done_n;
            lcd_e     <= (state_n == PULSE);
            if (load_cmd) begin
                lcd_rs <= cmd.cmd_rs;
                lcd_db <= cmd.cmd_data;
                clr_q  <= is_clear_class(cmd.cmd_rs, cmd.cmd_data);
            end
`ifdef LCD_INIT_SEQ_EN
            if (load_rom) begin
                lcd_rs <= 1'b0;
                lcd_db <= rom_data;
                clr_q  <= is_clear_class(1'b0, rom_data);
                last_q <= rom_last;
                idx    <= idx + 3'd1;
            end
`endif
        end
    end

endmodule
